button_scheduler: RTL and testbench
===================================

# button_scheduler

Front-panel input controller for the egg timer. It generates the shared sample-enable tick that drives every button debouncer. It watches the debounced button levels and grants ownership to one button at a time. It converts the owner's hold time into short-press, long-press and auto-repeat events, delivered to the timer core over a valid/ready handshake.

## Interface
- NUM_BUTTONS, 4: number of debounced button inputs (≥1).
- SAMPLE_DIV, 100000: clk cycles per sample tick (≥2).
- LONG_TICKS, 100: sample ticks a button must be held to produce a long press (≥2).
- REPEAT_TICKS, 20: sample ticks between auto-repeat events after a long press; 0 disables repeat.
- IDW: derived parameter, max(1, clog2(NUM_BUTTONS)).
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset; deassertion must be synchronous to clk.
- btn_level  in  NUM_BUTTONS  debounced button levels, 1 = pressed.
- sample_en  out  1  one-cycle tick; drives the enable input of every debouncer.
- press_valid  out  1  an event is pending.
- press_id  out  IDW  index of the button that produced the event.
- press_kind  out  2  event type: 0 = short, 1 = long, 2 = repeat; 3 is never driven.
- press_ready  in  1  consumer accepts the pending event.
- event_dropped  out  1  one-cycle pulse; an event was lost because the output was occupied.

## Operation
- Tick divider: counter runs 0..SAMPLE_DIV-1 and wraps. sample_en is registered and is high for exactly 1 cycle per SAMPLE_DIV cycles.
- FSM evaluates btn_level only in cycles where sample_en=1. Between ticks, no state changes except the output handshake.
- States:
  - IDLE: on a tick with any btn_level bit set, owner ← lowest set index, hold_cnt ← 0, go to HELD.
  - HELD: on a tick, if btn_level[owner]=0, emit short and go to RELEASE. Otherwise hold_cnt++. When the incremented value equals LONG_TICKS, emit long, rep_cnt ← 0, go to REPEAT.
  - REPEAT: on a tick, if btn_level[owner]=0, go to RELEASE with no event. Otherwise, if REPEAT_TICKS≠0, rep_cnt++. When it equals REPEAT_TICKS, emit repeat and rep_cnt ← 0.
  - RELEASE: on a tick with btn_level == 0, go to IDLE. Any still-held button is ignored until all buttons are released. This prevents phantom presses.
- Buttons other than the owner are ignored in HELD and REPEAT.
- Emit: load press_id ← owner, press_kind ← kind, and set press_valid.
- Output slot rules:
  - press_valid stays high, and press_id/press_kind stay stable, until a cycle with press_valid & press_ready. press_valid clears on the following edge.
  - If an emit coincides with acceptance of the pending event, the new event is loaded and press_valid stays 1.
  - If an emit occurs while press_valid=1 and press_ready=0, the new event is discarded, the FSM still advances, and event_dropped pulses 1 cycle.
- Counter widths: hold_cnt is clog2(LONG_TICKS+1); rep_cnt is clog2(REPEAT_TICKS+1), minimum 1. Neither counter wraps, because both reset on state change.

## Timing
- Reset (reset_n=0, immediate):
  - Outputs: sample_en=0, press_valid=0, press_id=0, press_kind=0, event_dropped=0.
  - Internal: FSM=IDLE, all counters=0.
- After reset_n rises, the first sample_en high cycle is the SAMPLE_DIV-th cycle.
- Event latency: press_valid rises on the clk edge that ends the deciding sample_en cycle, i.e. 1 clk after the tick.
- Long-press timing: with the entry tick at T, long is emitted at tick T+LONG_TICKS. Repeats follow at T+LONG_TICKS+k·REPEAT_TICKS.
- Reset mid-operation aborts any hold. The pending event is lost, and no event is emitted on recovery until a new IDLE→HELD entry.
- btn_level may change on any cycle; only its value in tick cycles matters.

## Test plan
Bench parameters: NUM_BUTTONS=4, SAMPLE_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
- Divider: release reset, press_ready=1 → sample_en high in cycles 4, 8, 12…, exactly 1 cycle wide. Assert reset_n=0 mid-count → sample_en=0 at once, and the next pulse comes 4 cycles after release.
- Short press: btn_level=4'b0010 for ticks T..T+1, 0 at T+2 → exactly one event (id=1, kind=0), press_valid high 1 clk after tick T+2.
- Long and repeat: btn_level=4'b0001 for ticks T..T+7, 0 at T+8 → events long@T+3, repeat@T+5, repeat@T+7, then nothing after release.
- Arbitration: btn_level=4'b1100 at the entry tick → owner=2. Release bit 2 while bit 3 stays held → short(id=2) only. FSM waits in RELEASE, and no event for id 3 until all released and re-pressed.
- Backpressure: press_ready=0 during the long-press sequence → long event held stable, the repeat at T+5 dropped with a 1-cycle event_dropped pulse. Raise press_ready → long accepted and press_valid drops next cycle.
- Reset in HELD: reset_n low at tick T+2 of a hold → press_valid=0 and FSM in IDLE. With the button still held after release, the next tick re-enters HELD and long is emitted 3 ticks later.

Source files
------------

// File: rtl/button_scheduler.sv
// Front-panel input controller: sample tick generator, single-owner
// button arbiter and short/long/repeat press event source.
module button_scheduler #(
  parameter int NUM_BUTTONS  = 4,
  parameter int SAMPLE_DIV   = 100000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int IDW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   sample_en,
  output logic                   press_valid,
  output logic [IDW-1:0]         press_id,
  output logic [1:0]             press_kind,
  input  logic                   press_ready,
  output logic                   event_dropped
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 0) ?
                      $clog2(REPEAT_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_REPEAT,
    S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    K_SHORT  = 2'd0,
    K_LONG   = 2'd1,
    K_REPEAT = 2'd2
  } kind_t;

  logic [DW-1:0]  div_cnt;
  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt, hold_inc;
  logic [RW-1:0]  rep_cnt, rep_nxt, rep_inc;
  logic [IDW-1:0] low_id;
  logic           any_btn;
  logic           owner_lvl;
  logic           emit;
  kind_t          emit_kind;
  logic           accept;

  // sample_en is registered: it rises as the count enters its last value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      sample_en <= 1'b0;
    end else begin
      sample_en <= (div_cnt == DW'(SAMPLE_DIV - 2));
      if (div_cnt == DW'(SAMPLE_DIV - 1))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    low_id = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (btn_level[i])
        low_id = IDW'(i);
    end
  end

  assign any_btn   = |btn_level;
  assign owner_lvl = btn_level[owner];
  assign hold_inc  = hold_cnt + HW'(1);
  assign rep_inc   = rep_cnt + RW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    rep_nxt   = rep_cnt;
    emit      = 1'b0;
    emit_kind = K_SHORT;
    if (sample_en) begin
      unique case (state)
        S_IDLE: begin
          if (any_btn) begin
            owner_nxt = low_id;
            hold_nxt  = '0;
            state_nxt = S_HELD;
          end
        end
        S_HELD: begin
          if (!owner_lvl) begin
            emit      = 1'b1;
            emit_kind = K_SHORT;
            state_nxt = S_RELEASE;
          end else if (hold_inc == HW'(LONG_TICKS)) begin
            emit      = 1'b1;
            emit_kind = K_LONG;
            rep_nxt   = '0;
            hold_nxt  = '0;
            state_nxt = S_REPEAT;
          end else begin
            hold_nxt  = hold_inc;
          end
        end
        S_REPEAT: begin
          if (!owner_lvl) begin
            rep_nxt   = '0;
            state_nxt = S_RELEASE;
          end else if (REPEAT_TICKS != 0) begin
            if (rep_inc == RW'(REPEAT_TICKS)) begin
              emit      = 1'b1;
              emit_kind = K_REPEAT;
              rep_nxt   = '0;
            end else begin
              rep_nxt   = rep_inc;
            end
          end
        end
        S_RELEASE: begin
          if (!any_btn)
            state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign accept = press_valid & press_ready;

  // a new event may replace one being accepted in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_valid   <= 1'b0;
      press_id      <= '0;
      press_kind    <= 2'd0;
      event_dropped <= 1'b0;
    end else begin
      event_dropped <= 1'b0;
      if (emit && (!press_valid || press_ready)) begin
        press_valid <= 1'b1;
        press_id    <= owner;
        press_kind  <= emit_kind;
      end else if (emit) begin
        event_dropped <= 1'b1;
      end else if (accept) begin
        press_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_scheduler.sv
// Bench for button_scheduler: divider timing, press classification,
// arbitration, backpressure and reset recovery against a scoreboard.
module tb_button_scheduler;

  localparam int NB  = 4;
  localparam int DIV = 4;
  localparam int LT  = 3;
  localparam int RT  = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] kind;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] btn_level;
  logic          sample_en;
  logic          press_valid;
  logic [1:0]    press_id;
  logic [1:0]    press_kind;
  logic          press_ready;
  logic          event_dropped;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  drop_cnt = 0;
  ev_t sb[$];
  logic       held_v = 1'b0;
  logic [1:0] held_id, held_kind;

  button_scheduler #(
    .NUM_BUTTONS (NB),
    .SAMPLE_DIV  (DIV),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_level    (btn_level),
    .sample_en    (sample_en),
    .press_valid  (press_valid),
    .press_id     (press_id),
    .press_kind   (press_kind),
    .press_ready  (press_ready),
    .event_dropped(event_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // negedges until sample_en is seen high
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      n++;
      if (sample_en) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  task automatic do_tick(input logic [NB-1:0] lvl, input bit ev,
                         input int id, input int kind);
    int n;
    ev_t e;
    btn_level = lvl;
    wait_tick(n);
    if (ev) begin
      e.id   = 2'(id);
      e.kind = 2'(kind);
      sb.push_back(e);
    end
    @(negedge clk);
    if (press_ready)
      chk("emit_at_tick", int'(press_valid), int'(ev));
    else if (ev)
      chk("emit_stalled", int'(press_valid), 1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (event_dropped) drop_cnt++;
    if (reset_n && press_valid && press_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("ev_id", int'(press_id), int'(e.id));
        chk("ev_kind", int'(press_kind), int'(e.kind));
      end
    end
    if (reset_n && press_valid && !press_ready) begin
      if (held_v) begin
        chk("stall_id", int'(press_id), int'(held_id));
        chk("stall_kind", int'(press_kind), int'(held_kind));
      end
      held_v    <= 1'b1;
      held_id   <= press_id;
      held_kind <= press_kind;
    end else begin
      held_v <= 1'b0;
    end
  end

  initial begin
    int n;
    int d0;
    reset_n     = 1'b0;
    btn_level   = '0;
    press_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sample_en", int'(sample_en), 0);
    chk("rst_valid", int'(press_valid), 0);
    chk("rst_id", int'(press_id), 0);
    chk("rst_kind", int'(press_kind), 0);
    chk("rst_dropped", int'(event_dropped), 0);

    // first tick lands in the DIV-th cycle after release
    reset_n = 1'b1;
    wait_tick(n);
    chk("div_first", n, DIV - 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("div_width", int'(sample_en), 0);
      wait_tick(n);
      chk("div_period", n, DIV - 1);
    end

    // async reset while the tick is high
    reset_n = 1'b0;
    #1;
    chk("div_async_rst", int'(sample_en), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick(n);
    chk("div_after_rst", n, DIV - 1);
    @(negedge clk);

    // short press on button 1
    do_tick(4'b0010, 0, 0, 0);
    do_tick(4'b0010, 0, 0, 0);
    do_tick(4'b0000, 1, 1, 0);
    do_tick(4'b0000, 0, 0, 0);

    // long press then repeats on button 0
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 1, 0, 1);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 1, 0, 2);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 1, 0, 2);
    do_tick(4'b0000, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);

    // lowest index wins; button 3 ignored until all released
    do_tick(4'b1100, 0, 0, 0);
    do_tick(4'b1100, 0, 0, 0);
    do_tick(4'b1000, 1, 2, 0);
    do_tick(4'b1000, 0, 0, 0);
    do_tick(4'b1000, 0, 0, 0);
    do_tick(4'b1000, 0, 0, 0);
    do_tick(4'b1000, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);
    do_tick(4'b1000, 0, 0, 0);
    do_tick(4'b0000, 1, 3, 0);
    do_tick(4'b0000, 0, 0, 0);

    // backpressure: long held, first repeat dropped
    press_ready = 1'b0;
    d0 = drop_cnt;
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 1, 0, 1);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);
    chk("bp_drop_pulses", drop_cnt - d0, 1);
    chk("bp_still_valid", int'(press_valid), 1);
    @(posedge clk);
    #1;
    press_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_cleared", int'(press_valid), 0);

    // reset during a hold
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    btn_level = 4'b0001;
    wait_tick(n);
    reset_n = 1'b0;
    #1;
    chk("hr_valid", int'(press_valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 0, 0, 0);
    do_tick(4'b0001, 1, 0, 1);
    do_tick(4'b0000, 0, 0, 0);
    do_tick(4'b0000, 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
